// File: rtl/opc_mem_bridge.sv
// opc_mem_bridge
//   Bridges a simple CPU request/ready interface onto an 8-bit multiplexed
//   address/data bus. The high address latch (addr[10:8]) is only refreshed
//   when the page differs from the one last latched.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   cpu_req           transfer request, sampled only in IDLE
//   cpu_addr[10:0]    byte address
//   cpu_rnw           1 = read, 0 = write
//   cpu_wdata[7:0]    write data
//   cpu_rdata[7:0]    read data, held until the next read completes
//   cpu_ready         one-cycle transfer-complete pulse
//   ext_ad_in[7:0]    multiplexed bus, input path
//   ext_ad_out[7:0]   multiplexed bus, output path
//   ext_ad_oe[7:0]    per-bit output enable (always 00 or FF)
//   ext_ale, ext_ahi  address-latch enable, high/low latch select
//   ext_rd_n, ext_wr_n active-low strobes
module opc_mem_bridge #(
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic [10:0] cpu_addr,
    input  logic        cpu_rnw,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ready,
    input  logic [7:0]  ext_ad_in,
    output logic [7:0]  ext_ad_out,
    output logic [7:0]  ext_ad_oe,
    output logic        ext_ale,
    output logic        ext_ahi,
    output logic        ext_rd_n,
    output logic        ext_wr_n
);

    localparam logic [2:0] WS_INIT = 3'(WAIT_STATES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALE_HI,
        S_ALE_LO,
        S_ACCESS,
        S_DONE
    } state_t;

    state_t      state, state_nxt;
    logic [10:0] addr_q;
    logic        rnw_q;
    logic [7:0]  wdata_q;
    logic [2:0]  hi_page;
    logic        hi_valid;
    logic [2:0]  wait_cnt;
    logic [7:0]  rdata_q;
    logic        page_hit;

    // Compared against the live input: on the capturing edge this is the
    // very address being latched.
    assign page_hit  = hi_valid && (cpu_addr[10:8] == hi_page);
    assign cpu_rdata = rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            rnw_q    <= 1'b0;
            wdata_q  <= '0;
            hi_page  <= '0;
            hi_valid <= 1'b0;
            wait_cnt <= '0;
            rdata_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cpu_req) begin
                        addr_q  <= cpu_addr;
                        rnw_q   <= cpu_rnw;
                        wdata_q <= cpu_wdata;
                    end
                end
                S_ALE_HI: begin
                    hi_page  <= addr_q[10:8];
                    hi_valid <= 1'b1;
                end
                S_ALE_LO: wait_cnt <= WS_INIT;
                S_ACCESS: begin
                    if (wait_cnt != 3'd0)
                        wait_cnt <= wait_cnt - 3'd1;
                    else if (rnw_q)
                        rdata_q <= ext_ad_in;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt  = state;
        cpu_ready  = 1'b0;
        ext_ad_out = 8'h00;
        ext_ad_oe  = 8'h00;
        ext_ale    = 1'b0;
        ext_ahi    = 1'b0;
        ext_rd_n   = 1'b1;
        ext_wr_n   = 1'b1;
        case (state)
            S_IDLE: begin
                if (cpu_req) state_nxt = page_hit ? S_ALE_LO : S_ALE_HI;
            end
            S_ALE_HI: begin
                ext_ad_out = {5'b0, addr_q[10:8]};
                ext_ad_oe  = 8'hFF;
                ext_ale    = 1'b1;
                ext_ahi    = 1'b1;
                state_nxt  = S_ALE_LO;
            end
            S_ALE_LO: begin
                ext_ad_out = addr_q[7:0];
                ext_ad_oe  = 8'hFF;
                ext_ale    = 1'b1;
                state_nxt  = S_ACCESS;
            end
            S_ACCESS: begin
                if (rnw_q) begin
                    ext_rd_n = 1'b0;
                end else begin
                    ext_wr_n   = 1'b0;
                    ext_ad_out = wdata_q;
                    ext_ad_oe  = 8'hFF;
                end
                if (wait_cnt == 3'd0) state_nxt = S_DONE;
            end
            S_DONE: begin
                cpu_ready = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_opc_mem_bridge.sv
// Randomized scoreboard bench for opc_mem_bridge. A byte-addressed external
// memory model sits on the multiplexed bus; a reference memory, page tracker
// and read-data register predict each transfer's outcome and timing.
module tb_opc_mem_bridge;
    localparam int WS = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        cpu_req, cpu_rnw;
    logic [10:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata, ext_ad_in, ext_ad_out, ext_ad_oe;
    logic        cpu_ready, ext_ale, ext_ahi, ext_rd_n, ext_wr_n;

    opc_mem_bridge #(.WAIT_STATES(WS)) dut (
        .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
        .cpu_rnw(cpu_rnw), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_ready(cpu_ready), .ext_ad_in(ext_ad_in), .ext_ad_out(ext_ad_out),
        .ext_ad_oe(ext_ad_oe), .ext_ale(ext_ale), .ext_ahi(ext_ahi),
        .ext_rd_n(ext_rd_n), .ext_wr_n(ext_wr_n)
    );

    // Zero-wait-state instance for the short-access case.
    logic        c0_req, c0_rnw;
    logic [10:0] c0_addr;
    logic [7:0]  c0_wdata, c0_rdata, e0_ad_in, e0_ad_out, e0_ad_oe;
    logic        c0_ready, e0_ale, e0_ahi, e0_rd_n, e0_wr_n;
    assign e0_ad_in = 8'hC3;

    opc_mem_bridge #(.WAIT_STATES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .cpu_req(c0_req), .cpu_addr(c0_addr),
        .cpu_rnw(c0_rnw), .cpu_wdata(c0_wdata), .cpu_rdata(c0_rdata),
        .cpu_ready(c0_ready), .ext_ad_in(e0_ad_in), .ext_ad_out(e0_ad_out),
        .ext_ad_oe(e0_ad_oe), .ext_ale(e0_ale), .ext_ahi(e0_ahi),
        .ext_rd_n(e0_rd_n), .ext_wr_n(e0_wr_n)
    );

    int total = 0;
    int bad = 0;
    int edges = 0;
    always @(posedge clk) edges <= edges + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] init_val(input logic [10:0] a);
        logic [7:0] h;
        h = a[7:0] ^ {a[10:8], a[10:8], 2'b01} ^ 8'h5A;
        return (a == 11'h1A5) ? 8'h3C : h;
    endfunction

    // External device: address latches plus byte memory.
    logic [7:0] ext_mem [2048];
    logic [2:0] lat_hi;
    logic [7:0] lat_lo;
    assign ext_ad_in = ext_mem[{lat_hi, lat_lo}];
    initial begin
        for (int i = 0; i < 2048; i++) ext_mem[i] = init_val(11'(i));
        lat_hi = '0;
        lat_lo = '0;
        forever begin
            @(posedge clk);
            if (!ext_wr_n) ext_mem[{lat_hi, lat_lo}] = ext_ad_out;
            if (ext_ale && ext_ahi)  lat_hi = ext_ad_out[2:0];
            if (ext_ale && !ext_ahi) lat_lo = ext_ad_out;
        end
    end

    typedef struct {
        logic        rnw;
        logic [10:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
        int          cap;
        int          lat;
        bit          hi;
    } exp_t;
    exp_t sbq[$];

    // Reference model state
    logic [7:0] ref_mem [2048];
    bit         ref_hv;
    logic [2:0] ref_pg;
    logic [7:0] ref_rd;

    // Monitor: accumulates bus activity per transfer, checks on cpu_ready.
    initial begin
        int n_ahi, n_alo, n_rd, n_wr, prot;
        logic [7:0] v_hi, v_lo, v_wd;
        exp_t e;
        n_ahi = 0; n_alo = 0; n_rd = 0; n_wr = 0; prot = 0;
        v_hi = '0; v_lo = '0; v_wd = '0;
        forever begin
            @(negedge clk);
            if (!ext_rd_n && !ext_wr_n) prot++;
            if ((!ext_rd_n || !ext_wr_n) && ext_ale) prot++;
            if (ext_ad_oe != 8'h00 && ext_ad_oe != 8'hFF) prot++;
            if (ext_ale && ext_ahi)  begin n_ahi++; v_hi = ext_ad_out; if (ext_ad_oe != 8'hFF) prot++; end
            if (ext_ale && !ext_ahi) begin n_alo++; v_lo = ext_ad_out; if (ext_ad_oe != 8'hFF) prot++; end
            if (!ext_rd_n) begin n_rd++; if (ext_ad_oe != 8'h00) prot++; end
            if (!ext_wr_n) begin n_wr++; v_wd = ext_ad_out; if (ext_ad_oe != 8'hFF) prot++; end
            if (!ext_ale && ext_rd_n && ext_wr_n &&
                (ext_ad_out != 8'h00 || ext_ad_oe != 8'h00 || ext_ahi)) prot++;
            if (cpu_ready) begin
                if (sbq.size() == 0) begin
                    chk("spurious_ready", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("latency", edges - e.cap, e.lat);
                    chk("rdata", cpu_rdata, e.rdata);
                    chk("ahi_cycles", n_ahi, e.hi ? 1 : 0);
                    if (e.hi) chk("ale_hi_val", v_hi, {5'b0, e.addr[10:8]});
                    chk("ale_lo_cycles", n_alo, 1);
                    chk("ale_lo_val", v_lo, e.addr[7:0]);
                    chk("rd_cycles", n_rd, e.rnw ? WS + 1 : 0);
                    chk("wr_cycles", n_wr, e.rnw ? 0 : WS + 1);
                    if (!e.rnw) chk("wr_data", v_wd, e.wdata);
                    chk("protocol", prot, 0);
                end
                n_ahi = 0; n_alo = 0; n_rd = 0; n_wr = 0; prot = 0;
            end else if (!ext_ale && ext_rd_n && ext_wr_n) begin
                n_ahi = 0; n_alo = 0; n_rd = 0; n_wr = 0; prot = 0;
            end
        end
    end

    task automatic model_reset();
        ref_hv = 0;
        ref_pg = '0;
        ref_rd = '0;
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_rd_n", ext_rd_n, 1);
        chk("rst_wr_n", ext_wr_n, 1);
        chk("rst_ready", cpu_ready, 0);
        chk("rst_oe", ext_ad_oe, 8'h00);
        chk("rst_rdata", cpu_rdata, 8'h00);
        cpu_req = 1'b0;
        #2 rst_n = 1'b1;
        sbq.delete();
        model_reset();
    endtask

    // Called at a negedge while the DUT is idle; returns at the negedge of
    // the following idle cycle.
    task automatic xfer(input logic rnw, input logic [10:0] addr, input logic [7:0] wd,
                        input bit hold, input bit wobble);
        exp_t e;
        int   n;
        cpu_req = 1'b1; cpu_rnw = rnw; cpu_addr = addr; cpu_wdata = wd;
        e.rnw = rnw; e.addr = addr; e.wdata = wd; e.cap = edges + 1;
        e.hi = !(ref_hv && ref_pg == addr[10:8]);
        e.lat = WS + (e.hi ? 3 : 2);
        ref_hv = 1; ref_pg = addr[10:8];
        if (rnw) ref_rd = ref_mem[addr];
        else     ref_mem[addr] = wd;
        e.rdata = ref_rd;
        sbq.push_back(e);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!hold) cpu_req = 1'b0;
            if (wobble) begin
                cpu_addr = 11'($urandom); cpu_rnw = 1'($urandom); cpu_wdata = 8'($urandom);
            end
        end while (!cpu_ready && n < 30);
        if (!cpu_ready) begin
            chk("ready_timeout", 0, 1);
            pulse_reset();
        end
        @(negedge clk);
    endtask

    initial begin
        logic [2:0] pg;
        logic [10:0] a;
        int n, lat0, ahi0, rd0;
        logic [7:0] hv0, lv0;
        for (int i = 0; i < 2048; i++) ref_mem[i] = init_val(11'(i));
        model_reset();
        cpu_req = 0; cpu_rnw = 0; cpu_addr = '0; cpu_wdata = '0;
        c0_req = 0; c0_rnw = 0; c0_addr = '0; c0_wdata = '0;
        repeat (3) @(negedge clk);
        chk("reset_rdata", cpu_rdata, 8'h00);
        chk("reset_ready", cpu_ready, 0);
        chk("reset_bus", {ext_ad_out, ext_ad_oe}, 16'h0000);
        chk("reset_ctl", {ext_ale, ext_ahi, ext_rd_n, ext_wr_n}, 4'b0011);
        rst_n = 1'b1;
        @(negedge clk);

        xfer(1, 11'h1A5, 8'h00, 0, 0);
        xfer(1, 11'h1A6, 8'h00, 0, 0);
        xfer(0, 11'h205, 8'h77, 0, 0);
        xfer(1, 11'h000, 8'h00, 0, 0);
        xfer(0, 11'h7FF, 8'hE1, 0, 0);
        xfer(1, 11'h7FF, 8'h00, 0, 0);

        // Request held high with operands changing mid-transfer.
        for (int k = 0; k < 12; k++)
            xfer(1'($urandom), {3'($urandom_range(0, 1)), 8'($urandom)}, 8'($urandom), 1, 1);
        cpu_req = 1'b0;

        // Reset during ACCESS of a read.
        cpu_req = 1'b1; cpu_rnw = 1'b1; cpu_addr = 11'h1A5;
        n = 0;
        do begin @(negedge clk); n++; cpu_req = 1'b0; end while (ext_rd_n && n < 20);
        chk("abort_reached_access", ext_rd_n, 0);
        pulse_reset();
        n = 0;
        do begin @(negedge clk); n++; end while (!cpu_ready && n < 8);
        chk("abort_no_ready", cpu_ready, 0);
        xfer(1, 11'h1A5, 8'h00, 0, 0);

        // Random traffic, biased towards page reuse.
        pg = 3'd0;
        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 3) == 0) pg = 3'($urandom);
            a = {pg, 8'($urandom)};
            xfer(1'($urandom), a, 8'($urandom), 1'($urandom), 1'($urandom));
            cpu_req = 1'b0;
        end

        // Zero wait states: read 0x7FF.
        c0_req = 1'b1; c0_rnw = 1'b1; c0_addr = 11'h7FF;
        lat0 = edges + 1;
        ahi0 = 0; rd0 = 0; hv0 = '0; lv0 = '0; n = 0;
        do begin
            @(negedge clk);
            n++;
            c0_req = 1'b0;
            if (e0_ale && e0_ahi)  begin ahi0++; hv0 = e0_ad_out; end
            if (e0_ale && !e0_ahi) lv0 = e0_ad_out;
            if (!e0_rd_n) rd0++;
        end while (!c0_ready && n < 20);
        chk("ws0_latency", edges - lat0, 3);
        chk("ws0_ale_hi", {ahi0[7:0], hv0}, 16'h0107);
        chk("ws0_ale_lo", lv0, 8'hFF);
        chk("ws0_rd_cycles", rd0, 1);
        chk("ws0_rdata", c0_rdata, 8'hC3);

        repeat (3) @(negedge clk);
        chk("queue_drained", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
